// File: rtl/audio_frame_rx_pkg.sv
// Shared constants for the framed stereo audio receiver: sync word defaults,
// frame length and the 3-bit state encoding of the frame FSM.
package audio_frame_rx_pkg;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;
    localparam int         FRAME_LEN     = 7;

    typedef logic [2:0] state_t;

    localparam state_t ST_HUNT   = 3'd0;
    localparam state_t ST_GOT_S0 = 3'd1;
    localparam state_t ST_L_LO   = 3'd2;
    localparam state_t ST_L_HI   = 3'd3;
    localparam state_t ST_R_LO   = 3'd4;
    localparam state_t ST_R_HI   = 3'd5;
    localparam state_t ST_CHK    = 3'd6;

endpackage

// File: rtl/audio_frame_rx_frame_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is in progress and
// pulses expire when the last allowed cycle passes without a byte.
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam int          CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    // A byte arriving in the expiry cycle suppresses the expiry.
    assign expire = enable && !kick && (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (!enable || kick || expire) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/audio_frame_rx.sv
// Framed stereo receiver: hunts for the sync word, assembles L/R samples,
// verifies the XOR checksum and issues one FIFO write per good frame.
module audio_frame_rx
    import audio_frame_rx_pkg::*;
#(
    parameter logic [7:0] SYNC0          = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1          = SYNC1_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 2048,
    parameter int         CNT_BITS       = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_received,
    input  logic [7:0]          rx_byte,
    input  logic                fifo_full,
    output logic                wr_en,
    output logic [31:0]         wr_data,
    output logic                locked,
    output logic [CNT_BITS-1:0] err_cnt,
    output logic [CNT_BITS-1:0] ovf_cnt
);

    state_t              state_q, state_d;
    logic                expire;
    logic [7:0]          acc_q;
    logic [31:0]         sample_q;
    logic                wr_en_q;
    logic [31:0]         wr_data_q;
    logic                locked_q;
    logic [CNT_BITS-1:0] err_cnt_q;
    logic [CNT_BITS-1:0] ovf_cnt_q;

    logic                acc_clear;
    logic                payload_we;
    logic                frame_good;
    logic                frame_ovf;
    logic                frame_err;

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (state_q != ST_HUNT),
        .kick   (rx_received),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_received) begin
            case (state_q)
                ST_HUNT:   state_d = (rx_byte == SYNC0) ? ST_GOT_S0 : ST_HUNT;
                ST_GOT_S0: begin
                    if (rx_byte == SYNC1) begin
                        state_d = ST_L_LO;
                    end else if (rx_byte == SYNC0) begin
                        state_d = ST_GOT_S0;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_L_LO:   state_d = ST_L_HI;
                ST_L_HI:   state_d = ST_R_LO;
                ST_R_LO:   state_d = ST_R_HI;
                ST_R_HI:   state_d = ST_CHK;
                default:   state_d = ST_HUNT;
            endcase
        end else if (expire) begin
            state_d = ST_HUNT;
        end
    end

    // Per-cycle action decode; payload bytes are never compared against sync.
    always_comb begin
        acc_clear  = 1'b0;
        payload_we = 1'b0;
        frame_good = 1'b0;
        frame_ovf  = 1'b0;
        frame_err  = 1'b0;
        if (rx_received) begin
            case (state_q)
                ST_GOT_S0: acc_clear = (rx_byte == SYNC1);
                ST_L_LO, ST_L_HI, ST_R_LO, ST_R_HI: payload_we = 1'b1;
                ST_CHK: begin
                    if (acc_q == rx_byte) begin
                        frame_ovf  = fifo_full;
                        frame_good = !fifo_full;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (expire) begin
            frame_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            sample_q <= '0;
        end else begin
            if (acc_clear) begin
                acc_q <= '0;
            end else if (payload_we) begin
                acc_q <= acc_q ^ rx_byte;
            end
            if (payload_we) begin
                case (state_q)
                    ST_L_LO: sample_q[7:0]   <= rx_byte;
                    ST_L_HI: sample_q[15:8]  <= rx_byte;
                    ST_R_LO: sample_q[23:16] <= rx_byte;
                    default: sample_q[31:24] <= rx_byte;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            wr_en_q <= frame_good;
            if (frame_good) begin
                wr_data_q <= sample_q;
                locked_q  <= 1'b1;
            end else if (frame_err) begin
                locked_q  <= 1'b0;
            end
            // Saturate rather than wrap so the LEDs never look healthy again.
            if (frame_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (frame_ovf && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign locked  = locked_q;
    assign err_cnt = err_cnt_q;
    assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_audio_frame_rx.sv
// Bench for audio_frame_rx: directed scenarios plus randomized frames, all
// checked against a byte-stream reference model with a write queue.
module tb_audio_frame_rx;

    localparam logic [7:0] S0 = 8'hA5;
    localparam logic [7:0] S1 = 8'h5A;
    localparam int         TMO = 2048;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        fifo_full = 1'b0;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        locked;
    logic [7:0]  err_cnt;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    bit full_noise = 1'b0;

    // Reference model: sync progress, collected payload, counters, expected writes.
    int          m_sync;
    logic [7:0]  m_pay[$];
    int          m_last_edge;
    int          m_err;
    int          m_ovf;
    bit          m_locked;
    logic [31:0] m_wr_data;
    logic [31:0] exp_q[$];
    int          exp_edge_q[$];

    audio_frame_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_received(rx_received),
        .rx_byte    (rx_byte),
        .fifo_full  (fifo_full),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .locked     (locked),
        .err_cnt    (err_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // Write monitor: every wr_en pulse must match the next expected write and edge.
    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: edge=%0d wr_data=%h, expected no write", edge_cnt, wr_data);
            end else begin
                logic [31:0] d;
                int e;
                d = exp_q.pop_front();
                e = exp_edge_q.pop_front();
                if (wr_data !== d || edge_cnt != e) begin
                    failures++;
                    $display("FAIL wr_data: got %h at edge %0d, expected %h at edge %0d", wr_data, edge_cnt, d, e);
                end
            end
        end
    end

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic void model_reset();
        m_sync = 0;
        m_pay.delete();
        m_last_edge = 0;
        m_err = 0;
        m_ovf = 0;
        m_locked = 1'b0;
        m_wr_data = 32'h0;
        exp_q.delete();
        exp_edge_q.delete();
    endfunction

    // Apply an inter-byte timeout if one has become visible by edge e.
    function automatic void model_advance(input int e);
        if (m_sync != 0 && e - m_last_edge >= TMO) begin
            m_err = sat_inc(m_err);
            m_locked = 1'b0;
            m_sync = 0;
            m_pay.delete();
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic full, input int q);
        logic [7:0] x;
        model_advance(q - 1);
        m_last_edge = q;
        if (m_sync == 0) begin
            if (b == S0) m_sync = 1;
        end else if (m_sync == 1) begin
            if (b == S1) begin
                m_sync = 2;
                m_pay.delete();
            end else if (b != S0) begin
                m_sync = 0;
            end
        end else begin
            m_pay.push_back(b);
            if (m_pay.size() == 5) begin
                x = m_pay[0] ^ m_pay[1] ^ m_pay[2] ^ m_pay[3];
                if (x == m_pay[4]) begin
                    if (full) begin
                        m_ovf = sat_inc(m_ovf);
                    end else begin
                        m_wr_data = {m_pay[3], m_pay[2], m_pay[1], m_pay[0]};
                        exp_q.push_back(m_wr_data);
                        exp_edge_q.push_back(q);
                        m_locked = 1'b1;
                    end
                end else begin
                    m_err = sat_inc(m_err);
                    m_locked = 1'b0;
                end
                m_sync = 0;
                m_pay.delete();
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input logic full);
        for (int i = 1; i < gap; i++) begin
            rx_received = 1'b0;
            fifo_full = full_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        rx_received = 1'b1;
        rx_byte = b;
        fifo_full = full;
        model_byte(b, full, edge_cnt + 1);
        @(negedge clk);
        rx_received = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic [7:0] chk_flip,
                              input logic full, input int gap, input int big_idx, input int big_gap);
        logic [7:0] b[7];
        logic nf;
        b = '{S0, S1, l[7:0], l[15:8], r[7:0], r[15:8],
              l[7:0] ^ l[15:8] ^ r[7:0] ^ r[15:8] ^ chk_flip};
        for (int i = 0; i < 7; i++) begin
            nf = (i == 6) ? full : (full_noise ? 1'($urandom_range(0, 1)) : 1'b0);
            send_byte(b[i], (i == big_idx) ? big_gap : gap, nf);
        end
    endtask

    task automatic settle();
        rx_received = 1'b0;
        @(negedge clk);
        #1;
        model_advance(edge_cnt);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #12;
        checks += 5;
        if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", locked); end
        if (err_cnt !== 8'h0) begin failures++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        if (ovf_cnt !== 8'h0) begin failures++; $display("FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        send_frame(16'h1234, 16'h5678, 8'h00, 1'b0, 521, -1, 0);
        settle();
        checks += 4;
        if (wr_data !== 32'h5678_1234) begin failures++; $display("FAIL good_wr_data: got %h expected 56781234", wr_data); end
        if (locked !== 1'b1) begin failures++; $display("FAIL good_locked: got %b expected 1", locked); end
        if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL good_err_cnt: got %0d expected %0d", err_cnt, m_err); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL good_missing_write: %0d pending", exp_q.size()); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] frm[7];
        frm = '{S0, S1, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0F};
        for (int i = 0; i < 7; i++) send_byte(frm[i], 3, 1'b0);
        settle();
        checks += 3;
        if (err_cnt !== 8'd1 || err_cnt !== 8'(m_err)) begin failures++; $display("FAIL badchk_err_cnt: got %0d expected 1", err_cnt); end
        if (locked !== 1'b0) begin failures++; $display("FAIL badchk_locked: got %b expected 0", locked); end
        if (wr_data !== 32'h5678_1234) begin failures++; $display("FAIL badchk_wr_hold: got %h expected 56781234", wr_data); end
        send_frame(16'h2211, 16'h4433, 8'h00, 1'b0, 1, -1, 0);
        settle();
        checks += 3;
        if (wr_data !== 32'h4433_2211) begin failures++; $display("FAIL recover_wr_data: got %h expected 44332211", wr_data); end
        if (locked !== 1'b1) begin failures++; $display("FAIL recover_locked: got %b expected 1", locked); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL recover_missing_write: %0d pending", exp_q.size()); end
    endtask

    task automatic test_garbage_resync();
        logic [7:0] seq[9];
        int e0;
        e0 = m_err;
        seq = '{8'h00, S0, S0, S1, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        for (int i = 0; i < 9; i++) send_byte(seq[i], 2, 1'b0);
        settle();
        checks += 3;
        if (wr_data !== 32'h0002_0001) begin failures++; $display("FAIL garbage_wr_data: got %h expected 00020001", wr_data); end
        if (err_cnt !== 8'(e0)) begin failures++; $display("FAIL garbage_err_cnt: got %0d expected %0d", err_cnt, e0); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL garbage_missing_write: %0d pending", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int p, e0;
        e0 = m_err;
        send_byte(S0, 1, 1'b0);
        send_byte(S1, 1, 1'b0);
        send_byte(8'h01, 1, 1'b0);
        send_byte(8'h02, 1, 1'b0);
        p = m_last_edge;
        while (edge_cnt < p + TMO - 1) @(negedge clk);
        #1;
        checks += 2;
        if (err_cnt !== 8'(e0)) begin failures++; $display("FAIL timeout_early: got %0d expected %0d", err_cnt, e0); end
        if (locked !== 1'b1) begin failures++; $display("FAIL timeout_early_locked: got %b expected 1", locked); end
        @(negedge clk);
        #1;
        model_advance(edge_cnt);
        checks += 2;
        if (err_cnt !== 8'(e0 + 1) || err_cnt !== 8'(m_err)) begin failures++; $display("FAIL timeout_err_cnt: got %0d expected %0d", err_cnt, e0 + 1); end
        if (locked !== 1'b0) begin failures++; $display("FAIL timeout_locked: got %b expected 0", locked); end
        while (edge_cnt < p + 3000) @(negedge clk);
        send_frame(16'hBEEF, 16'hCAFE, 8'h00, 1'b0, 1, -1, 0);
        settle();
        checks += 2;
        if (wr_data !== 32'hCAFE_BEEF) begin failures++; $display("FAIL after_timeout_wr_data: got %h expected cafebeef", wr_data); end
        if (locked !== 1'b1) begin failures++; $display("FAIL after_timeout_locked: got %b expected 1", locked); end
        // Byte arriving exactly on the expiry cycle is still accepted.
        send_frame(16'h0A0B, 16'h0C0D, 8'h00, 1'b0, 1, 4, TMO);
        settle();
        checks += 2;
        if (wr_data !== 32'h0C0D_0A0B) begin failures++; $display("FAIL gap_edge_wr_data: got %h expected 0c0d0a0b", wr_data); end
        if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL gap_edge_err_cnt: got %0d expected %0d", err_cnt, m_err); end
        // One cycle later the frame is already abandoned.
        e0 = m_err;
        send_frame(16'h0201, 16'h0403, 8'h00, 1'b0, 1, 6, TMO + 1);
        settle();
        checks += 3;
        if (err_cnt !== 8'(e0 + 1)) begin failures++; $display("FAIL gap_late_err_cnt: got %0d expected %0d", err_cnt, e0 + 1); end
        if (wr_data !== 32'h0C0D_0A0B) begin failures++; $display("FAIL gap_late_wr_hold: got %h expected 0c0d0a0b", wr_data); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL timeout_missing_write: %0d pending", exp_q.size()); end
    endtask

    task automatic test_overflow();
        bit l0;
        send_frame(16'h1111, 16'h2222, 8'h00, 1'b0, 1, -1, 0);
        settle();
        l0 = m_locked;
        send_frame(16'h3333, 16'h4444, 8'h00, 1'b1, 1, -1, 0);
        settle();
        checks += 3;
        if (ovf_cnt !== 8'd1 || ovf_cnt !== 8'(m_ovf)) begin failures++; $display("FAIL ovf_one: got %0d expected 1", ovf_cnt); end
        if (locked !== l0) begin failures++; $display("FAIL ovf_locked: got %b expected %b", locked, l0); end
        if (wr_data !== 32'h2222_1111) begin failures++; $display("FAIL ovf_wr_hold: got %h expected 22221111", wr_data); end
        for (int i = 0; i < 299; i++) begin
            send_frame(16'($urandom), 16'($urandom), 8'h00, 1'b1, 1, -1, 0);
        end
        settle();
        checks += 2;
        if (ovf_cnt !== 8'hFF || ovf_cnt !== 8'(m_ovf)) begin failures++; $display("FAIL ovf_saturate: got %0d expected 255", ovf_cnt); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_missing_write: %0d pending", exp_q.size()); end
    endtask

    task automatic test_reset_midframe();
        send_byte(S0, 1, 1'b0);
        send_byte(S1, 1, 1'b0);
        send_byte(8'h11, 1, 1'b0);
        send_byte(8'h22, 1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks += 5;
        if (wr_en !== 1'b0) begin failures++; $display("FAIL arst_wr_en: got %b expected 0", wr_en); end
        if (wr_data !== 32'h0) begin failures++; $display("FAIL arst_wr_data: got %h expected 0", wr_data); end
        if (locked !== 1'b0) begin failures++; $display("FAIL arst_locked: got %b expected 0", locked); end
        if (err_cnt !== 8'h0) begin failures++; $display("FAIL arst_err_cnt: got %0d expected 0", err_cnt); end
        if (ovf_cnt !== 8'h0) begin failures++; $display("FAIL arst_ovf_cnt: got %0d expected 0", ovf_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h33, 1, 1'b0);
        send_byte(8'h44, 1, 1'b0);
        send_byte(8'h44, 1, 1'b0);
        settle();
        checks += 2;
        if (wr_data !== 32'h0) begin failures++; $display("FAIL arst_tail_wr_data: got %h expected 0", wr_data); end
        if (err_cnt !== 8'h0) begin failures++; $display("FAIL arst_tail_err_cnt: got %0d expected 0", err_cnt); end
        send_frame(16'h5566, 16'h7788, 8'h00, 1'b0, 2, -1, 0);
        settle();
        checks += 2;
        if (wr_data !== 32'h7788_5566) begin failures++; $display("FAIL arst_next_wr_data: got %h expected 77885566", wr_data); end
        if (locked !== 1'b1) begin failures++; $display("FAIL arst_next_locked: got %b expected 1", locked); end
    endtask

    task automatic test_random();
        logic [15:0] l, r;
        logic [7:0]  flip;
        logic        full;
        int          big_idx;
        full_noise = 1'b1;
        for (int f = 0; f < 120; f++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                send_byte(8'($urandom), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            end
            l = 16'($urandom);
            r = 16'($urandom);
            if ($urandom_range(0, 7) == 0) l[7:0] = S0;
            if ($urandom_range(0, 7) == 0) r[15:8] = S0;
            flip = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            full = ($urandom_range(0, 4) == 0);
            big_idx = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 6)) : -1;
            send_frame(l, r, flip, full, $urandom_range(1, 6), big_idx, TMO - 1 + int'($urandom_range(0, 3)));
            settle();
            checks += 5;
            if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL rand_err_cnt[%0d]: got %0d expected %0d", f, err_cnt, m_err); end
            if (ovf_cnt !== 8'(m_ovf)) begin failures++; $display("FAIL rand_ovf_cnt[%0d]: got %0d expected %0d", f, ovf_cnt, m_ovf); end
            if (locked !== m_locked) begin failures++; $display("FAIL rand_locked[%0d]: got %b expected %b", f, locked, m_locked); end
            if (wr_data !== m_wr_data) begin failures++; $display("FAIL rand_wr_data[%0d]: got %h expected %h", f, wr_data, m_wr_data); end
            if (exp_q.size() != 0) begin failures++; $display("FAIL rand_missing_write[%0d]: %0d pending", f, exp_q.size()); end
        end
        full_noise = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_garbage_resync();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        test_random();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL final_pending_writes: got %0d expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
